// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with writeback forwarding and two-entry skid buffer
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [REGW-1:0] in_rs1,
  input  logic [REGW-1:0] in_rs2,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_use_imm,
  input  logic [2:0]      in_op,
  input  logic            in_is_fp,
  input  logic [REGW-1:0] in_rd,
  input  logic            in_we,
  input  logic            wb_valid,
  input  logic            wb_is_fp,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_A,
  output logic [XLEN-1:0] alu_B,
  output logic [2:0]      alu_Op,
  output logic            alu_is_fp,
  output logic [REGW-1:0] out_rd,
  output logic            out_we
);

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      op;
    logic            is_fp;
    logic [REGW-1:0] rd;
    logic            we;
  } entry_t;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, new_entry;
  logic   in_ready_q, in_ready_d;
  logic   accept, transfer, fwd_rs1, fwd_rs2;

  assign accept   = in_valid & in_ready_q;
  assign transfer = (state_q != EMPTY) & out_ready;

  // Integer x0 is hard-wired zero, so it never takes a forwarded value.
  always_comb begin
    fwd_rs1 = wb_valid && (wb_rd == in_rs1) && (wb_is_fp == in_is_fp) &&
              (in_is_fp || (in_rs1 != '0));
    fwd_rs2 = wb_valid && (wb_rd == in_rs2) && (wb_is_fp == in_is_fp) &&
              (in_is_fp || (in_rs2 != '0));
    new_entry.a     = fwd_rs1 ? wb_data : in_rs1_val;
    new_entry.b     = in_use_imm ? in_imm : (fwd_rs2 ? wb_data : in_rs2_val);
    new_entry.op    = in_op;
    new_entry.is_fp = in_is_fp;
    new_entry.rd    = in_rd;
    new_entry.we    = in_we;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          main_d  = new_entry;
        end
      end
      ONE: begin
        if (accept && transfer) begin
          main_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = TWO;
        end else if (transfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (transfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops the valids only; data registers keep their stale contents.
    if (flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign alu_A     = main_q.a;
  assign alu_B     = main_q.b;
  assign alu_Op    = main_q.op;
  assign alu_is_fp = main_q.is_fp;
  assign out_rd    = main_q.rd;
  assign out_we    = main_q.we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd, out_rd;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, wb_data, alu_A, alu_B;
  logic        in_use_imm, in_is_fp, in_we, wb_valid, wb_is_fp;
  logic        out_valid, out_ready, alu_is_fp, out_we;
  logic [2:0]  in_op, alu_Op;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_op(in_op), .in_is_fp(in_is_fp),
    .in_rd(in_rd), .in_we(in_we),
    .wb_valid(wb_valid), .wb_is_fp(wb_is_fp), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_Op(alu_Op), .alu_is_fp(alu_is_fp),
    .out_rd(out_rd), .out_we(out_we)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [4:0] rs1, input logic [31:0] a_val,
                       input logic [4:0] rs2, input logic [31:0] b_val,
                       input logic use_imm, input logic [31:0] imm,
                       input logic [2:0] op, input logic is_fp, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_rs1     = rs1;
    in_rs1_val = a_val;
    in_rs2     = rs2;
    in_rs2_val = b_val;
    in_use_imm = use_imm;
    in_imm     = imm;
    in_op      = op;
    in_is_fp   = is_fp;
    in_rd      = rd;
    in_we      = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_alu_A"}, alu_A, 32'd0);
    check({tag, "_alu_B"}, alu_B, 32'd0);
    check({tag, "_alu_Op"}, {29'd0, alu_Op}, 32'd0);
    check({tag, "_alu_is_fp"}, {31'd0, alu_is_fp}, 32'd0);
    check({tag, "_out_rd"}, {27'd0, out_rd}, 32'd0);
    check({tag, "_out_we"}, {31'd0, out_we}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rs1_val = '0; in_rs2_val = '0;
    in_imm = '0; in_use_imm = 1'b0; in_op = '0; in_is_fp = 1'b0; in_rd = '0; in_we = 1'b0;
    wb_valid = 1'b0; wb_is_fp = 1'b0; wb_rd = '0; wb_data = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single ADD, held under stall, then consumed
    instr(5'd1, 32'd5, 5'd2, 32'd7, 1'b0, 32'd0, 3'b000, 1'b0, 5'd9);
    tick();
    in_valid = 1'b0;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_A", alu_A, 32'd5);
    check("add_B", alu_B, 32'd7);
    check("add_Op", {29'd0, alu_Op}, 32'd0);
    check("add_rd", {27'd0, out_rd}, 32'd9);
    check("add_we", {31'd0, out_we}, 32'd1);
    tick();
    check("add_hold_valid", {31'd0, out_valid}, 32'd1);
    check("add_hold_A", alu_A, 32'd5);
    check("add_hold_B", alu_B, 32'd7);
    out_ready = 1'b1;
    tick();
    check("add_consumed", {31'd0, out_valid}, 32'd0);

    // Immediate select and back-to-back forwarding cases at full throughput
    instr(5'd1, 32'd3, 5'd2, 32'd9, 1'b1, 32'hFFFF_FFFC, 3'b110, 1'b0, 5'd4);
    tick();
    check("imm_B", alu_B, 32'hFFFF_FFFC);
    check("imm_Op", {29'd0, alu_Op}, 32'd6);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_ABCD; wb_is_fp = 1'b0;
    instr(5'd3, 32'd1, 5'd5, 32'd2, 1'b0, 32'd0, 3'b000, 1'b0, 5'd6);
    tick();
    check("fwd_rs1_A", alu_A, 32'h0000_ABCD);
    check("fwd_rs1_B", alu_B, 32'd2);
    wb_rd = 5'd0;
    instr(5'd0, 32'd1, 5'd5, 32'd2, 1'b0, 32'd0, 3'b000, 1'b0, 5'd6);
    tick();
    check("fwd_x0_A", alu_A, 32'd1);
    wb_rd = 5'd3; wb_is_fp = 1'b1;
    instr(5'd3, 32'd1, 5'd5, 32'd2, 1'b0, 32'd0, 3'b000, 1'b0, 5'd6);
    tick();
    check("fwd_file_mismatch_A", alu_A, 32'd1);
    wb_rd = 5'd0;
    instr(5'd0, 32'd1, 5'd5, 32'd2, 1'b0, 32'd0, 3'b001, 1'b1, 5'd6);
    tick();
    check("fwd_fp_f0_A", alu_A, 32'h0000_ABCD);
    check("fwd_fp_is_fp", {31'd0, alu_is_fp}, 32'd1);
    wb_rd = 5'd4; wb_is_fp = 1'b0;
    instr(5'd1, 32'd1, 5'd4, 32'd2, 1'b0, 32'd0, 3'b000, 1'b0, 5'd6);
    tick();
    check("fwd_rs2_B", alu_B, 32'h0000_ABCD);
    instr(5'd1, 32'd1, 5'd4, 32'd2, 1'b1, 32'h0000_0011, 3'b000, 1'b0, 5'd6);
    tick();
    check("fwd_rs2_imm_B", alu_B, 32'h0000_0011);
    wb_valid = 1'b0;
    in_valid = 1'b0;
    tick();
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Back-pressure: two stall cycles fill the skid, then I0..I3 drain in order
    out_ready = 1'b0;
    instr(5'd1, 32'h10, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    check("bp_I0_A", alu_A, 32'h10);
    check("bp_one_in_ready", {31'd0, in_ready}, 32'd1);
    instr(5'd1, 32'h11, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    check("bp_two_A", alu_A, 32'h10);
    check("bp_two_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    instr(5'd1, 32'h12, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    check("bp_I1_A", alu_A, 32'h11);
    check("bp_I1_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_I2_A", alu_A, 32'h12);
    instr(5'd1, 32'h13, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    check("bp_I3_A", alu_A, 32'h13);
    check("bp_I3_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Flush from TWO with an instruction presented, then flush in ONE discarding an accept
    out_ready = 1'b0;
    instr(5'd1, 32'h20, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    instr(5'd1, 32'h21, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    check("fl_two_in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    instr(5'd1, 32'h22, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_two_valid", {31'd0, out_valid}, 32'd0);
    check("fl_two_in_ready_after", {31'd0, in_ready}, 32'd1);
    instr(5'd1, 32'h23, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    check("fl_one_A", alu_A, 32'h23);
    flush = 1'b1;
    instr(5'd1, 32'h24, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("fl_one_valid", {31'd0, out_valid}, 32'd0);
    check("fl_one_stale_A", alu_A, 32'h23);
    tick();
    check("fl_nothing_reappears", {31'd0, out_valid}, 32'd0);
    instr(5'd1, 32'h30, 5'd2, 32'd0, 1'b0, 32'd0, 3'b000, 1'b0, 5'd1);
    tick();
    in_valid = 1'b0;
    check("fl_recover_A", alu_A, 32'h30);
    check("fl_recover_valid", {31'd0, out_valid}, 32'd1);
    tick();

    // Asynchronous reset mid-cycle while in TWO
    out_ready = 1'b0;
    instr(5'd1, 32'h31, 5'd2, 32'd5, 1'b0, 32'd0, 3'b011, 1'b1, 5'd7);
    tick();
    instr(5'd1, 32'h32, 5'd2, 32'd5, 1'b0, 32'd0, 3'b011, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    check("ar_two_in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    instr(5'd1, 32'h40, 5'd2, 32'd8, 1'b0, 32'd0, 3'b010, 1'b0, 5'd3);
    tick();
    in_valid = 1'b0;
    check("ar_first_valid", {31'd0, out_valid}, 32'd1);
    check("ar_first_A", alu_A, 32'h40);
    check("ar_first_Op", {29'd0, alu_Op}, 32'd2);
    tick();
    check("ar_drained", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
